// File: rtl/front_panel_pkg.sv
// Shared types and helpers for the front panel: step FSM states and the
// active-low seven-segment encoding {g,f,e,d,c,b,a}.
package front_panel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PULSE    = 2'd1,
        ST_WAIT_REL = 2'd2
    } step_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] i_nib);
        logic [6:0] w_seg;
        case (i_nib)
            4'h0:    w_seg = 7'h40;
            4'h1:    w_seg = 7'h79;
            4'h2:    w_seg = 7'h24;
            4'h3:    w_seg = 7'h30;
            4'h4:    w_seg = 7'h19;
            4'h5:    w_seg = 7'h12;
            4'h6:    w_seg = 7'h02;
            4'h7:    w_seg = 7'h78;
            4'h8:    w_seg = 7'h00;
            4'h9:    w_seg = 7'h10;
            4'hA:    w_seg = 7'h08;
            4'hB:    w_seg = 7'h03;
            4'hC:    w_seg = 7'h46;
            4'hD:    w_seg = 7'h21;
            4'hE:    w_seg = 7'h06;
            default: w_seg = 7'h0E;
        endcase
        return w_seg;
    endfunction

endpackage

// File: rtl/front_panel_debouncer.sv
// Two-flop synchronizer plus consecutive-cycle debounce for one panel input.
// o_level_nxt is the level o_level will take on the next clock edge.
module debouncer #(
    parameter int DB_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset_cpu,
    input  logic i_raw,
    output logic o_level,
    output logic o_level_nxt
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_last;

    assign w_diff      = r_sync2 ^ r_level;
    assign w_last      = (r_cnt == CW'(DB_CYCLES - 1));
    assign o_level     = r_level;
    assign o_level_nxt = (w_diff && w_last) ? ~r_level : r_level;

    always_ff @(posedge clk or posedge reset_cpu) begin
        if (reset_cpu) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_level <= o_level_nxt;
            // Any cycle that agrees with the stable level restarts the count.
            if (w_diff && !w_last) r_cnt <= r_cnt + CW'(1);
            else                   r_cnt <= '0;
        end
    end

endmodule

// File: rtl/front_panel.sv
// CPU front panel: single-step / free-run control and a multiplexed
// 4-digit hex display of the CPU output word, plus a PC LED mirror.
//
// state       | meaning
// ST_IDLE     | waiting for an accepted button press
// ST_PULSE    | one-cycle CPU advance strobe
// ST_WAIT_REL | press consumed, waiting for debounced release
module front_panel
    import front_panel_pkg::*;
#(
    parameter int DB_CYCLES = 100000,
    parameter int SCAN_BITS = 16
) (
    input  logic        clk,
    input  logic        reset_cpu,
    input  logic        btn_step,
    input  logic        sw_run,
    input  logic [15:0] output_port,
    input  logic [7:0]  PC_below8bit,
    output logic        cpu_enable,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [7:0]  led
);
    localparam int SW = SCAN_BITS + 2;

    logic          w_btn_db;
    logic          w_btn_nxt;
    logic          w_sw_db;
    logic          w_sw_nxt;
    logic          r_btn_rise;
    step_state_t   r_state;
    step_state_t   w_state_nxt;
    logic          r_cpu_en;
    logic [SW-1:0] r_scan;
    logic [15:0]   r_disp;
    logic [1:0]    w_digit;
    logic [3:0]    w_nib;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;
    logic [7:0]    r_led;

    debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_btn (
        .clk         (clk),
        .reset_cpu   (reset_cpu),
        .i_raw       (btn_step),
        .o_level     (w_btn_db),
        .o_level_nxt (w_btn_nxt)
    );

    debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_sw (
        .clk         (clk),
        .reset_cpu   (reset_cpu),
        .i_raw       (sw_run),
        .o_level     (w_sw_db),
        .o_level_nxt (w_sw_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (r_btn_rise) w_state_nxt = ST_PULSE;
            ST_PULSE:    w_state_nxt = ST_WAIT_REL;
            ST_WAIT_REL: if (!w_btn_db) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // cpu_enable is registered from next-state values so it tracks
    // (state == PULSE) | debounced sw_run on the same edge they change.
    always_ff @(posedge clk or posedge reset_cpu) begin
        if (reset_cpu) begin
            r_state    <= ST_IDLE;
            r_btn_rise <= 1'b0;
            r_cpu_en   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_btn_rise <= w_btn_nxt & ~w_btn_db;
            r_cpu_en   <= (w_state_nxt == ST_PULSE) | w_sw_nxt;
        end
    end

    assign w_digit = r_scan[SW-1 -: 2];
    assign w_nib   = r_disp[{w_digit, 2'b00} +: 4];

    // The display word only changes as the counter wraps, so a frame never mixes words.
    always_ff @(posedge clk or posedge reset_cpu) begin
        if (reset_cpu) begin
            r_scan <= '0;
            r_disp <= '0;
            r_seg  <= SEG_BLANK;
            r_an   <= 4'hF;
            r_led  <= 8'h00;
        end else begin
            r_scan <= r_scan + SW'(1);
            if (&r_scan) r_disp <= output_port;
            r_seg  <= hex_to_seg(w_nib);
            r_an   <= ~(4'b0001 << w_digit);
            r_led  <= PC_below8bit;
        end
    end

    assign cpu_enable = r_cpu_en;
    assign seg        = r_seg;
    assign an         = r_an;
    assign led        = r_led;

endmodule

// File: tb/tb_front_panel.sv
// Scoreboard bench for front_panel with DB_CYCLES=4, SCAN_BITS=2.
module tb_front_panel;

    logic        clk = 1'b0;
    logic        reset_cpu = 1'b1;
    logic        btn_step = 1'b0;
    logic        sw_run = 1'b0;
    logic [15:0] output_port = 16'h0000;
    logic [7:0]  PC_below8bit = 8'h00;
    logic        cpu_enable;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [7:0]  led;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_pulse = 0;
    int p0 = 0;

    int          q_en[$];
    logic [10:0] q_disp[$];
    logic [7:0]  q_led[$];
    bit          disp_chk = 1'b0;
    bit          led_chk = 1'b0;
    logic [3:0]  prev_an = 4'hF;
    int          last_chg = -1;
    int          m_en;
    logic [10:0] m_disp;
    logic [7:0]  m_led;
    logic [7:0]  led_vec [6] = '{8'hA5, 8'h3C, 8'hFF, 8'h01, 8'h80, 8'h5A};

    front_panel #(.DB_CYCLES(4), .SCAN_BITS(2)) dut (
        .clk          (clk),
        .reset_cpu    (reset_cpu),
        .btn_step     (btn_step),
        .sw_run       (sw_run),
        .output_port  (output_port),
        .PC_below8bit (PC_below8bit),
        .cpu_enable   (cpu_enable),
        .seg          (seg),
        .an           (an),
        .led          (led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (q_en.size() > 0 && cyc > q_en[0]) begin
            n_tests++;
            n_fail++;
            m_en = q_en.pop_front();
            $display("FAIL cpu_enable_missing cycle=%0d actual=0 expected=1", m_en);
        end
        if (!reset_cpu && cpu_enable) begin
            n_pulse++;
            n_tests++;
            if (q_en.size() == 0) begin
                n_fail++;
                $display("FAIL cpu_enable_unexpected cycle=%0d actual=1 expected=0", cyc);
            end else begin
                m_en = q_en.pop_front();
                if (m_en != cyc) begin
                    n_fail++;
                    $display("FAIL cpu_enable_cycle actual=%0d expected=%0d", cyc, m_en);
                end
            end
        end
        if (disp_chk && an != prev_an) begin
            n_tests++;
            if (q_disp.size() == 0) begin
                n_fail++;
                $display("FAIL display_unexpected actual an=%b seg=%h", an, seg);
            end else begin
                m_disp = q_disp.pop_front();
                if ({an, seg} !== m_disp)
                begin
                    n_fail++;
                    $display("FAIL display_digit actual an=%b seg=%h expected an=%b seg=%h",
                             an, seg, m_disp[10:7], m_disp[6:0]);
                end
            end
            if (last_chg >= 0) begin
                n_tests++;
                if (cyc - last_chg != 4) begin
                    n_fail++;
                    $display("FAIL display_dwell actual=%0d expected=4", cyc - last_chg);
                end
            end
            last_chg = cyc;
        end
        prev_an = an;
        if (led_chk && q_led.size() > 0) begin
            n_tests++;
            m_led = q_led.pop_front();
            if (led !== m_led) begin
                n_fail++;
                $display("FAIL led_delay actual=%h expected=%h", led, m_led);
            end
        end
    end

    task automatic wait_empty(input int which, input string nm);
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk); #1;
            if ((which == 0 ? q_en.size() : q_disp.size()) == 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s pending=%0d expected=0", nm,
                     (which == 0 ? q_en.size() : q_disp.size()));
        end
    endtask

    task automatic wait_an(input logic [3:0] v);
        bit ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (an == v) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_an actual=%b expected=%b", an, v);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cpu_enable", cpu_enable, 32'h0);
        chk("rst_seg", seg, 32'h7F);
        chk("rst_an", an, 32'hF);
        chk("rst_led", led, 32'h00);
        reset_cpu = 1'b0;
        repeat (5) @(negedge clk);
        #1;

        // Glitch shorter than the debounce window.
        p0 = n_pulse;
        btn_step = 1'b1;
        repeat (3) @(negedge clk);
        #1 btn_step = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        chk("short_press_pulses", n_pulse - p0, 0);

        // Long hold gives one pulse; release then press gives exactly one more.
        p0 = n_pulse;
        btn_step = 1'b1;
        q_en.push_back(cyc + 7);
        repeat (30) @(negedge clk);
        #1 btn_step = 1'b0;
        repeat (10) @(negedge clk);
        #1 btn_step = 1'b1;
        q_en.push_back(cyc + 7);
        repeat (15) @(negedge clk);
        #1 btn_step = 1'b0;
        wait_empty(0, "long_press_drain");
        repeat (10) @(negedge clk);
        #1;
        chk("long_press_pulses", n_pulse - p0, 2);

        // Free-run switch.
        p0 = n_pulse;
        sw_run = 1'b1;
        for (int k = 6; k <= 25; k++) q_en.push_back(cyc + k);
        repeat (20) @(negedge clk);
        #1 sw_run = 1'b0;
        wait_empty(0, "sw_run_drain");
        repeat (8) @(negedge clk);
        #1;
        chk("sw_run_cycles", n_pulse - p0, 20);

        // LED is a one-cycle delayed copy; the input is disturbed after each capture.
        led_chk = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            PC_below8bit = led_vec[k];
            q_led.push_back(led_vec[k]);
            @(posedge clk); #1;
            PC_below8bit = ~led_vec[k];
        end
        @(negedge clk); #1;
        led_chk = 1'b0;

        // Asynchronous reset in the middle of a cycle.
        PC_below8bit = 8'hC3;
        @(negedge clk); #1;
        chk("pre_reset_led", led, 32'hC3);
        @(posedge clk); #2;
        reset_cpu = 1'b1;
        #1;
        chk("async_rst_cpu_enable", cpu_enable, 32'h0);
        chk("async_rst_seg", seg, 32'h7F);
        chk("async_rst_an", an, 32'hF);
        chk("async_rst_led", led, 32'h00);
        repeat (2) @(negedge clk);
        #1 reset_cpu = 1'b0;
        repeat (5) @(negedge clk);
        #1;

        // Reset while the strobe is high; button held through reset release.
        p0 = n_pulse;
        btn_step = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("pulse_started", cpu_enable, 32'h1);
        #1 reset_cpu = 1'b1;
        #1;
        chk("rst_in_pulse", cpu_enable, 32'h0);
        repeat (3) @(negedge clk);
        #1 reset_cpu = 1'b0;
        q_en.push_back(cyc + 7);
        repeat (15) @(negedge clk);
        #1 btn_step = 1'b0;
        wait_empty(0, "post_reset_press");
        repeat (10) @(negedge clk);
        #1;
        chk("reset_pulse_count", n_pulse - p0, 1);

        // Display frames: word change mid-frame only shows from the next frame.
        output_port = 16'h1A2F;
        wait_an(4'b1110);
        wait_an(4'b0111);
        q_disp.push_back({4'b1110, 7'h0E});
        q_disp.push_back({4'b1101, 7'h24});
        q_disp.push_back({4'b1011, 7'h08});
        q_disp.push_back({4'b0111, 7'h79});
        q_disp.push_back({4'b1110, 7'h40});
        q_disp.push_back({4'b1101, 7'h40});
        q_disp.push_back({4'b1011, 7'h40});
        q_disp.push_back({4'b0111, 7'h40});
        q_disp.push_back({4'b1110, 7'h40});
        disp_chk = 1'b1;
        for (int k = 0; k < 40 && q_disp.size() > 7; k++) begin
            @(negedge clk); #1;
        end
        output_port = 16'h0000;
        wait_empty(1, "display_drain");
        disp_chk = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/front_panel.md
FRONT_PANEL -- requirements
Module: front_panel

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 100000, meaning consecutive clean cycles required to accept an input change.
REQ-002 SHALL have parameter SCAN_BITS, default 16, meaning each display digit is shown for 2^SCAN_BITS cycles.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-004 SHALL have port reset_cpu, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port btn_step, input, 1, raw asynchronous pushbutton, high = pressed.
REQ-006 SHALL have port sw_run, input, 1, raw asynchronous switch, high = free-run.
REQ-007 SHALL have port output_port, input, 16, CPU output word to display.
REQ-008 SHALL have port PC_below8bit, input, 8, CPU PC low byte.
REQ-009 SHALL have port cpu_enable, output, 1, registered CPU advance strobe.
REQ-010 SHALL have port seg, output, 7, active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port an, output, 4, active-low digit enables; bit 0 = least significant nibble.
REQ-012 SHALL have port led, output, 8, registered copy of PC_below8bit.

Function
REQ-013 SHALL pass btn_step and sw_run through 2-flop synchronizers before any other use.
REQ-014 SHALL debounce each synchronized input: the stable level flips on the DB_CYCLES-th consecutive edge at which the synced value differs from it; any matching cycle clears the count.
REQ-015 SHALL implement step FSM states IDLE, PULSE, WAIT_REL.
REQ-016 IDLE -> PULSE on a debounced btn rising edge; PULSE -> WAIT_REL unconditionally after one cycle; WAIT_REL -> IDLE when debounced btn is low.
REQ-017 SHALL drive cpu_enable = (state == PULSE) OR debounced sw_run, registered; exactly one pulse per accepted press.
REQ-018 A press held indefinitely SHALL produce no further pulses; a new pulse requires a debounced release then press.
REQ-019 With debounced sw_run high, cpu_enable SHALL be 1 every cycle and presses SHALL still be tracked by the FSM without extra effect.
REQ-020 SHALL keep a free-running (SCAN_BITS+2)-bit scan counter, wrapping to 0; top 2 bits select the digit, an = ~(1 << digit).
REQ-021 SHALL capture output_port into a display register on the cycle the scan counter wraps to 0, so a full 4-digit frame never mixes two words.
REQ-022 SHALL drive seg from the selected display nibble via hex decode: 0->0x40, 1->0x79, 2->0x24, 8->0x00, A->0x08, F->0x0E; all 16 values defined.
REQ-023 seg and an SHALL be registered together, changing on the same edge.
REQ-024 led SHALL equal PC_below8bit delayed by exactly one cycle.

Reset
REQ-025 reset_cpu SHALL asynchronously force cpu_enable=0, seg=0x7F (blank), an=0xF, led=0x00, FSM=IDLE, all counters, synchronizers, debounced levels and display register to 0.
REQ-026 Reset during PULSE SHALL drop cpu_enable immediately and never complete that pulse.
REQ-027 A button held through reset release SHALL generate one pulse after normal debounce latency.

Structure
REQ-028 Shared package front_panel_pkg SHALL hold the FSM state enum, the SEG_BLANK constant and the hex-to-segment function.
REQ-029 Debounce + synchronizer SHALL be sub-module debouncer, instantiated once for btn_step and once for sw_run.

Verification (DB_CYCLES=4, SCAN_BITS=2)
REQ-030 Pulse reset_cpu mid-cycle -> all outputs at REQ-025 values before next clk edge.
REQ-031 btn_step high 3 cycles then low -> cpu_enable never asserts.
REQ-032 btn_step rises before edge 1, held 30 cycles -> cpu_enable high only in the cycle after edge 7; released 10 cycles then pressed again -> exactly one more pulse.
REQ-033 sw_run held high 20 cycles -> cpu_enable continuous from cycle after edge 6; sw_run low -> cpu_enable 0 after matching debounce latency.
REQ-034 output_port=0x1A2F held -> frame an 1110/1101/1011/0111 with seg 0x0E/0x24/0x08/0x79, 4 cycles each; change to 0x0000 mid-frame -> current frame unchanged, next frame all 0x40.
REQ-035 Assert reset_cpu during PULSE -> cpu_enable 0 asynchronously, no pulse after release until a new debounced press.
